div_sqrt_iter: RTL and testbench
================================

DIV_SQRT_ITER -- requirements
Module: div_sqrt_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >= 4.
REQ-002 SHALL have parameter TAG_W, default 4, width of the request tag.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of any in-flight or held operation.
REQ-006 SHALL have port inReady  output  1  high when a request can be accepted.
REQ-007 SHALL have port inValid  input  1  request present.
REQ-008 SHALL have port op  input  2  operation: 00 unsigned divide, 01 signed divide, 10 unsigned integer square root, 11 reserved.
REQ-009 SHALL have port tagIn  input  TAG_W  request identifier.
REQ-010 SHALL have port a  input  WIDTH  dividend or radicand.
REQ-011 SHALL have port b  input  WIDTH  divisor; ignored for sqrt.
REQ-012 SHALL have port outValid  output  1  result present.
REQ-013 SHALL have port outReady  input  1  consumer accepts the result.
REQ-014 SHALL have port tagOut  output  TAG_W  tag of the returned result.
REQ-015 SHALL have port quotient  output  WIDTH  quotient, or floor(sqrt(a)).
REQ-016 SHALL have port remainder  output  WIDTH  remainder, or a - root*root.
REQ-017 SHALL have port exceptionFlags  output  2  {divByZero, overflow}.

Function
REQ-018 SHALL implement states IDLE, ITER, FIX, DONE.
REQ-019 SHALL drive inReady = (state == IDLE) && !flush.
REQ-020 SHALL accept a request on a cycle where inValid && inReady are both high, capture op/tag/operands, and move IDLE->ITER.
REQ-021 SHALL treat op 11 as unsigned divide.
REQ-022 SHALL resolve one quotient bit per ITER cycle: WIDTH cycles for divide, WIDTH/2 cycles for sqrt (radix-2 restoring), then move ITER->FIX.
REQ-023 In FIX, SHALL apply sign correction and special cases, then move to DONE.
REQ-024 SHALL assert outValid exactly WIDTH+2 cycles (divide) or WIDTH/2+2 cycles (sqrt) after the accept edge, independent of operand values.
REQ-025 SHALL hold outValid, tagOut, quotient, remainder and exceptionFlags stable in DONE until outReady is high, then move DONE->IDLE.
REQ-026 SHALL NOT accept a new request in the same cycle a result is consumed; inReady rises one cycle later.
REQ-027 Signed divide SHALL divide magnitudes, negate the quotient when operand signs differ, and give the remainder the sign of the dividend.
REQ-028 Divide by zero SHALL return quotient all-ones, remainder = a, divByZero = 1, for both signed and unsigned divide.
REQ-029 Signed overflow (a = most-negative, b = -1) SHALL return quotient = a, remainder = 0, overflow = 1.
REQ-030 exceptionFlags SHALL be 0 for sqrt and for all other cases.
REQ-031 flush SHALL force state to IDLE and drop outValid on the next edge from any state; it has priority over accept and consume.
REQ-032 Results of a flushed operation SHALL never appear on the outputs.

Reset
REQ-033 On reset assertion, state SHALL go to IDLE asynchronously; outValid = 0, inReady = 0 while reset is high, tagOut/quotient/remainder/exceptionFlags = 0.
REQ-034 Reset mid-operation SHALL discard the operation with no output.

Structure
REQ-035 Op encodings, state encoding and flag bit positions SHALL live in a shared package div_sqrt_pkg.
REQ-036 The per-cycle shift/subtract step SHALL be one sub-module, div_sqrt_step, shared by divide and sqrt.
REQ-037 The block SHALL contain no multiplier and no combinational divider.

Verification (WIDTH=8)
REQ-038 Unsigned divide: a=200, b=7, tag=3 -> after 10 cycles, quotient=28, remainder=4, flags=00, tagOut=3.
REQ-039 Signed divide: a=-7 (0xF9), b=2 -> quotient=0xFD (-3), remainder=0xFF (-1); a=0x80, b=0xFF -> quotient=0x80, remainder=0, overflow=1.
REQ-040 Divide by zero: a=0x55, b=0 -> quotient=0xFF, remainder=0x55, divByZero=1.
REQ-041 Sqrt: a=200 -> after 6 cycles, quotient=14, remainder=4; a=255 -> quotient=15, remainder=30.
REQ-042 Backpressure: outReady held low 5 cycles -> outputs stable, inReady low; outReady=1 -> IDLE next cycle.
REQ-043 Abort: flush raised mid-ITER, and separately reset raised mid-ITER -> no outValid, inReady high again (after reset deasserts); the next request completes correctly.

Source files
------------

// File: rtl/div_sqrt_pkg.sv
// Shared encodings for the iterative divide / square-root unit:
// operation codes, controller states and exception flag bit positions.
package div_sqrt_pkg;

    typedef enum logic [1:0] {
        OP_UDIV = 2'b00,
        OP_SDIV = 2'b01,
        OP_SQRT = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // exceptionFlags = {divByZero, overflow}
    localparam int FLAG_DBZ = 1;
    localparam int FLAG_OVF = 0;

endpackage

// File: rtl/div_sqrt_step.sv
// One radix-2 restoring step shared by divide (one dividend bit brought down)
// and square root (two radicand bits brought down, trial value 4*root+1).
module div_sqrt_step #(
    parameter int WIDTH = 32
) (
    input  logic             sqrt_mode,
    input  logic [WIDTH-1:0] rem_in,
    input  logic [1:0]       bits_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] root_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH+1:0] partial;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] diff;

    always_comb begin
        if (sqrt_mode) begin
            partial = {rem_in, bits_in};
            trial   = {root_in, 2'b01};
        end else begin
            partial = {1'b0, rem_in, bits_in[1]};
            trial   = {2'b00, divisor};
        end
    end

    // A successful subtraction always leaves a value that fits in WIDTH bits,
    // so the low bits alone give the exact difference.
    assign q_bit   = (partial >= trial);
    assign diff    = partial[WIDTH-1:0] - trial[WIDTH-1:0];
    assign rem_out = q_bit ? diff : partial[WIDTH-1:0];

endmodule

// File: rtl/div_sqrt_iter.sv
// Iterative unsigned/signed divider and integer square root with a
// valid/ready request side, a held result side and a synchronous flush.
module div_sqrt_iter
    import div_sqrt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    output logic             inReady,
    input  logic             inValid,
    input  logic [1:0]       op,
    input  logic [TAG_W-1:0] tagIn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             outValid,
    input  logic             outReady,
    output logic [TAG_W-1:0] tagOut,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       exceptionFlags
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e            state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              sqrt_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              dbz_reg;
    logic              ovf_reg;
    logic [WIDTH-1:0]  a_raw_reg;
    logic [WIDTH-1:0]  num_reg;
    logic [WIDTH-1:0]  den_reg;
    logic [WIDTH-1:0]  rem_reg;
    logic [WIDTH-1:0]  quo_reg;
    logic              out_valid_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [TAG_W-1:0]  tag_out_reg;
    logic [WIDTH-1:0]  quotient_reg;
    logic [WIDTH-1:0]  remainder_reg;
    logic [1:0]        flags_reg;

    logic              is_sqrt;
    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH-1:0]  step_rem;
    logic              step_bit;
    logic [WIDTH-1:0]  quotient_next;
    logic [WIDTH-1:0]  remainder_next;
    logic [1:0]        flags_next;

    // Reserved op 11 falls through to unsigned divide.
    assign is_sqrt   = (op == OP_SQRT);
    assign is_signed = (op == OP_SDIV);
    assign a_neg     = is_signed && a[WIDTH-1];
    assign b_neg     = is_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;

    assign inReady        = (state_reg == IDLE) && !flush && !reset;
    assign outValid       = out_valid_reg;
    assign tagOut         = tag_out_reg;
    assign quotient       = quotient_reg;
    assign remainder      = remainder_reg;
    assign exceptionFlags = flags_reg;

    div_sqrt_step #(.WIDTH(WIDTH)) u_step (
        .sqrt_mode (sqrt_reg),
        .rem_in    (rem_reg),
        .bits_in   (num_reg[WIDTH-1:WIDTH-2]),
        .divisor   (den_reg),
        .root_in   (quo_reg),
        .rem_out   (step_rem),
        .q_bit     (step_bit)
    );

    // Special cases override the magnitude result computed by the iterations.
    always_comb begin
        flags_next           = '0;
        flags_next[FLAG_DBZ] = dbz_reg;
        flags_next[FLAG_OVF] = ovf_reg;
        if (dbz_reg) begin
            quotient_next  = '1;
            remainder_next = a_raw_reg;
        end else if (ovf_reg) begin
            quotient_next  = a_raw_reg;
            remainder_next = '0;
        end else begin
            quotient_next  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
            remainder_next = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            sqrt_reg      <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            a_raw_reg     <= '0;
            num_reg       <= '0;
            den_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            tag_reg       <= '0;
            out_valid_reg <= 1'b0;
            tag_out_reg   <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            flags_reg     <= '0;
        end else if (flush) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (inValid) begin
                        state_reg <= ITER;
                        sqrt_reg  <= is_sqrt;
                        tag_reg   <= tagIn;
                        a_raw_reg <= a;
                        num_reg   <= is_sqrt ? a : a_mag;
                        den_reg   <= b_mag;
                        rem_reg   <= '0;
                        quo_reg   <= '0;
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        dbz_reg   <= !is_sqrt && (b == '0);
                        ovf_reg   <= is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                        count_reg <= is_sqrt ? CNT_W'(WIDTH/2 - 1) : CNT_W'(WIDTH - 1);
                    end
                end
                ITER: begin
                    rem_reg   <= step_rem;
                    quo_reg   <= {quo_reg[WIDTH-2:0], step_bit};
                    num_reg   <= sqrt_reg ? {num_reg[WIDTH-3:0], 2'b00}
                                          : {num_reg[WIDTH-2:0], 1'b0};
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == '0) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    state_reg     <= DONE;
                    out_valid_reg <= 1'b1;
                    tag_out_reg   <= tag_reg;
                    quotient_reg  <= quotient_next;
                    remainder_reg <= remainder_next;
                    flags_reg     <= flags_next;
                end
                DONE: begin
                    if (outReady) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sqrt_iter.sv
// Directed bench for div_sqrt_iter at WIDTH=8: divide, signed divide, special
// cases, sqrt, latency, backpressure, flush and reset aborts.
module tb_div_sqrt_iter;
    localparam int W  = 8;
    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          inReady;
    logic          inValid = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [TW-1:0] tagIn = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [TW-1:0] tagOut;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic [1:0]    exceptionFlags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    div_sqrt_iter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .inReady        (inReady),
        .inValid        (inValid),
        .op             (op),
        .tagIn          (tagIn),
        .a              (a),
        .b              (b),
        .outValid       (outValid),
        .outReady       (outReady),
        .tagOut         (tagOut),
        .quotient       (quotient),
        .remainder      (remainder),
        .exceptionFlags (exceptionFlags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and let it be accepted on the next rising edge.
    task automatic start(input logic [1:0] o, input logic [TW-1:0] t,
                         input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(negedge clock);
        op = o; tagIn = t; a = aa; b = bb; inValid = 1'b1;
        check("in_ready_before_accept", 32'(inReady), 32'd1);
        @(posedge clock);
        #1 inValid = 1'b0;
    endtask

    // Latency counts the accept edge as 1; bounded by a cycle budget.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!outValid && lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
        end
    endtask

    task automatic consume();
        @(negedge clock);
        outReady = 1'b1;
        check("in_ready_low_in_consume_cycle", 32'(inReady), 32'd0);
        @(posedge clock);
        #1;
        check("out_valid_after_consume", 32'(outValid), 32'd0);
        check("in_ready_after_consume", 32'(inReady), 32'd1);
        outReady = 1'b0;
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [TW-1:0] t,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input int exp_lat, input logic [W-1:0] exp_q,
                       input logic [W-1:0] exp_r, input logic [1:0] exp_f);
        int lat;
        start(o, t, aa, bb);
        wait_result(lat);
        $display("txn %s op=%0d tag=%0d a=0x%02h b=0x%02h -> q=0x%02h r=0x%02h flags=%b tag=%0d lat=%0d",
                 name, o, t, aa, bb, quotient, remainder, exceptionFlags, tagOut, lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_quotient"}, 32'(quotient), 32'(exp_q));
        check({name, "_remainder"}, 32'(remainder), 32'(exp_r));
        check({name, "_flags"}, 32'(exceptionFlags), 32'(exp_f));
        check({name, "_tag"}, 32'(tagOut), 32'(t));
        consume();
    endtask

    task automatic watch_silent(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            if (outValid) seen = 1'b1;
        end
        $display("txn %s aborted, outValid seen=%0d inReady=%0d", name, seen, inReady);
        check({name, "_no_out_valid"}, 32'(seen), 32'd0);
        check({name, "_in_ready_again"}, 32'(inReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("reset_in_ready", 32'(inReady), 32'd0);
        check("reset_out_valid", 32'(outValid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_flags", 32'(exceptionFlags), 32'd0);
        check("reset_tag", 32'(tagOut), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1 check("idle_in_ready", 32'(inReady), 32'd1);

        run("udiv_200_7",   2'b00, 4'd3, 8'd200, 8'd7,   10, 8'd28,  8'd4,  2'b00);
        run("sdiv_m7_2",    2'b01, 4'd5, 8'hF9,  8'h02,  10, 8'hFD,  8'hFF, 2'b00);
        run("sdiv_7_m2",    2'b01, 4'd6, 8'h07,  8'hFE,  10, 8'hFD,  8'h01, 2'b00);
        run("sdiv_ovf",     2'b01, 4'd7, 8'h80,  8'hFF,  10, 8'h80,  8'h00, 2'b01);
        run("udiv_by_zero", 2'b00, 4'd8, 8'h55,  8'h00,  10, 8'hFF,  8'h55, 2'b10);
        run("sdiv_by_zero", 2'b01, 4'd9, 8'hF9,  8'h00,  10, 8'hFF,  8'hF9, 2'b10);
        run("sqrt_200",     2'b10, 4'd1, 8'd200, 8'd0,    6, 8'd14,  8'd4,  2'b00);
        run("sqrt_255",     2'b10, 4'd2, 8'd255, 8'd9,    6, 8'd15,  8'd30, 2'b00);
        run("op11_100_9",   2'b11, 4'd4, 8'd100, 8'd9,   10, 8'd11,  8'd1,  2'b00);

        // Backpressure: result must hold while outReady stays low.
        begin
            int lat;
            start(2'b00, 4'd10, 8'd50, 8'd6);
            wait_result(lat);
            check("bp_latency", 32'(lat), 32'd10);
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                check("bp_out_valid_held", 32'(outValid), 32'd1);
                check("bp_in_ready_low", 32'(inReady), 32'd0);
                check("bp_quotient_held", 32'(quotient), 32'd8);
                check("bp_remainder_held", 32'(remainder), 32'd2);
                check("bp_tag_held", 32'(tagOut), 32'd10);
            end
            $display("txn backpressure tag=10 a=50 b=6 -> q=%0d r=%0d held 5 cycles", quotient, remainder);
            consume();
        end

        // Flush in the middle of iterating.
        start(2'b00, 4'd11, 8'd77, 8'd3);
        repeat (3) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        #1 check("flush_in_ready_low", 32'(inReady), 32'd0);
        @(negedge clock);
        flush = 1'b0;
        watch_silent("flush_mid_iter");
        run("after_flush", 2'b00, 4'd12, 8'd99, 8'd10, 10, 8'd9, 8'd9, 2'b00);

        // Reset in the middle of iterating.
        start(2'b10, 4'd13, 8'd144, 8'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_mid_in_ready", 32'(inReady), 32'd0);
        check("reset_mid_out_valid", 32'(outValid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        watch_silent("reset_mid_iter");
        run("after_reset", 2'b10, 4'd14, 8'd16, 8'd0, 6, 8'd4, 8'd0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
